// File: rtl/irq_prio_ctrl_if.sv
// Interrupt controller bus: peripheral request lines, CPU handshake and
// controller status, grouped so the controller sees a single slave port.
interface irq_prio_ctrl_if #(
  parameter int INPUT_QTY = 8
);
  localparam int W = (INPUT_QTY > 1) ? $clog2(INPUT_QTY) : 1;

  logic                 ena;
  logic [INPUT_QTY-1:0] ins;
  logic [INPUT_QTY-1:0] mask;
  logic                 ack;
  logic                 eoi;
  logic                 irq_req;
  logic [W-1:0]         vec;
  logic                 in_service;
  logic [INPUT_QTY-1:0] pending;

  // Controller side
  modport slave (
    input  ena, ins, mask, ack, eoi,
    output irq_req, vec, in_service, pending
  );

  // Peripheral / CPU side
  modport master (
    output ena, ins, mask, ack, eoi,
    input  irq_req, vec, in_service, pending
  );
endinterface

// File: rtl/irq_prio_ctrl.sv
// Edge-latched interrupt priority controller. Rising edges on the request
// lines set pending bits; unmasked pending bits are arbitrated (fixed or
// rotating priority) and one registered request plus vector is offered to
// the CPU, closed by an ack / end-of-interrupt handshake.
module irq_prio_ctrl #(
  parameter int INPUT_QTY = 8,
  parameter bit ROTATE    = 1'b0
) (
  input logic             clk,
  input logic             rst,
  irq_prio_ctrl_if.slave  bus
);

  localparam int W = (INPUT_QTY > 1) ? $clog2(INPUT_QTY) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [INPUT_QTY-1:0] ins_q;
  logic [INPUT_QTY-1:0] pending_q, pending_d;
  logic [INPUT_QTY-1:0] rise;
  logic [INPUT_QTY-1:0] eligible;
  logic [INPUT_QTY-1:0] clr;
  logic                 any_elig;
  logic [W-1:0]         winner;
  logic                 irq_req_q, irq_req_d;
  logic                 in_service_q, in_service_d;
  logic [W-1:0]         vec_q, vec_d;
  logic [W-1:0]         rot_ptr_q, rot_ptr_d;

  // Priority scan starting just above ptr and wrapping: index ptr+k (mod N)
  // for larger k has higher priority, so ptr-1 is the top and ptr itself the
  // bottom. With ptr=0 this is plain highest-index-wins.
  function automatic logic [W-1:0] pick_winner(
    input logic [INPUT_QTY-1:0] elig,
    input logic [W-1:0]         ptr
  );
    logic [W-1:0] win;
    int           idx;
    win = '0;
    for (int k = 0; k < INPUT_QTY; k++) begin
      idx = int'(ptr) + k;
      if (idx >= INPUT_QTY) idx = idx - INPUT_QTY;
      if (elig[idx]) win = W'(idx);
    end
    return win;
  endfunction

  assign rise     = bus.ins & ~ins_q;
  assign eligible = pending_q & ~bus.mask;
  assign any_elig = |eligible;
  assign winner   = pick_winner(eligible, rot_ptr_q);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; losing enable or all eligible requests in REQ takes
  // precedence over an ack arriving in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.ena && any_elig) state_d = S_REQ;
      end
      S_REQ: begin
        if (!bus.ena || !any_elig) state_d = S_IDLE;
        else if (bus.ack)          state_d = S_SERVICE;
      end
      S_SERVICE: begin
        if (bus.eoi) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs and datapath next values; a new rise on the acked channel
  // re-sets its pending bit because set is OR-ed in after the clear
  always_comb begin
    irq_req_d    = (state_d == S_REQ);
    in_service_d = (state_d == S_SERVICE);
    vec_d        = vec_q;
    rot_ptr_d    = rot_ptr_q;
    clr          = '0;
    if (state_d == S_REQ) vec_d = winner;
    if (state_q == S_REQ && state_d == S_SERVICE) begin
      clr[vec_q] = 1'b1;
      if (ROTATE) rot_ptr_d = vec_q;
    end
    pending_d = (pending_q & ~clr) | rise;
  end

  // Edge detector, pending latch and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      ins_q        <= '0;
      pending_q    <= '0;
      irq_req_q    <= 1'b0;
      in_service_q <= 1'b0;
      vec_q        <= '0;
      rot_ptr_q    <= '0;
    end else begin
      ins_q        <= bus.ins;
      pending_q    <= pending_d;
      irq_req_q    <= irq_req_d;
      in_service_q <= in_service_d;
      vec_q        <= vec_d;
      rot_ptr_q    <= rot_ptr_d;
    end
  end

  assign bus.irq_req    = irq_req_q;
  assign bus.in_service = in_service_q;
  assign bus.vec        = vec_q;
  assign bus.pending    = pending_q;

endmodule
